mem_wb_reg: RTL and testbench

- MEM→WB pipeline register of the five-stage MIPS core; its outputs drive the write-back stage and the WB→ID forwarding register.
- Selects the write-back value (ALU result, load data, PC+8), extends sub-word loads, and registers it with the control and debug fields.
- Supports stall (hold) and flush (bubble). Keeps a retired-instruction counter for the bench.

---
 rtl/mem_wb_reg_pkg.sv | 22 ++
 rtl/mem_wb_reg_load.sv | 42 ++++
 rtl/mem_wb_reg.sv | 122 ++++++++++++
 tb/tb_mem_wb_reg.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_reg_pkg.sv
// Shared encodings for the MEM->WB boundary: write-back source selects,
// load opcodes and the reset PC.
// Pure declarations; no latency and no flow control.
package mem_wb_reg_pkg;

  // Write-back source select carried in Mem2Reg
  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MEM = 2'b01;
  localparam logic [1:0] M2R_PC8 = 2'b10;
  localparam logic [1:0] M2R_RSV = 2'b11;

  // Primary opcodes (instr[31:26]) of the load family
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;

  // PC presented by the pipeline while in reset
  localparam logic [31:0] RESET_PC = 32'h0000_3000;

endpackage

// File: rtl/mem_wb_reg_load.sv
// Load extractor: picks the byte/halfword addressed by off and extends it.
// Latency: purely combinational.
// Backpressure: none; output follows the inputs.
module load_ext
  import mem_wb_reg_pkg::*;
(
  input  logic [5:0]  i_opcode,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_word,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Byte lane select; halfword uses only the upper offset bit
  always_comb begin
    w_byte = i_word[7:0];
    case (i_off)
      2'd0: w_byte = i_word[7:0];
      2'd1: w_byte = i_word[15:8];
      2'd2: w_byte = i_word[23:16];
      2'd3: w_byte = i_word[31:24];
      default: w_byte = i_word[7:0];
    endcase
    w_half = i_off[1] ? i_word[31:16] : i_word[15:0];
  end

  // Extension by opcode; unknown opcodes pass the full word through
  always_comb begin
    o_data = i_word;
    case (i_opcode)
      OP_LB:   o_data = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  o_data = {24'h0, w_byte};
      OP_LH:   o_data = {{16{w_half[15]}}, w_half};
      OP_LHU:  o_data = {16'h0, w_half};
      OP_LW:   o_data = i_word;
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/mem_wb_reg.sv
// MEM->WB pipeline register: selects/extends the write-back value and
// registers it with control/debug fields; latency one cycle, all outputs registered.
// Backpressure: stall_W holds every register; flush_W (higher priority) loads a bubble.
module mem_wb_reg
  import mem_wb_reg_pkg::*;
#(
  parameter logic [31:0] RESET_PC = mem_wb_reg_pkg::RESET_PC,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_W,
  input  logic             flush_W,
  input  logic             valid_M,
  input  logic             RegWrite_M,
  input  logic [1:0]       Mem2Reg_M,
  input  logic [4:0]       WRegAdd_M,
  input  logic [31:0]      instr_M,
  input  logic [31:0]      ALUout_M,
  input  logic [31:0]      DMout_M,
  input  logic [31:0]      PC_M,
  output logic             valid_W,
  output logic             RegWrite_W,
  output logic [1:0]       Mem2Reg_W,
  output logic [4:0]       WRegAdd_W,
  output logic [31:0]      instr_W,
  output logic [31:0]      result_W,
  output logic [31:0]      PC_W,
  output logic [31:0]      PC8_W,
  output logic [CNT_W-1:0] retire_cnt
);

  logic             r_valid;
  logic             r_regwrite;
  logic [1:0]       r_mem2reg;
  logic [4:0]       r_wregadd;
  logic [31:0]      r_instr;
  logic [31:0]      r_result;
  logic [31:0]      r_pc;
  logic [31:0]      r_pc8;
  logic [CNT_W-1:0] r_retire_cnt;

  logic [31:0] w_load;
  logic [31:0] w_pc8;
  logic [31:0] w_result;
  logic        w_regwrite;

  load_ext u_load_ext (
    .i_opcode (instr_M[31:26]),
    .i_off    (ALUout_M[1:0]),
    .i_word   (DMout_M),
    .o_data   (w_load)
  );

  assign w_pc8 = PC_M + 32'd8;
  // $0 is hard-wired zero, so a write to it is dropped here rather than in the GRF
  assign w_regwrite = RegWrite_M & valid_M & (WRegAdd_M != 5'd0);

  // Write-back source mux; the reserved encoding yields zero
  always_comb begin
    w_result = 32'h0;
    case (Mem2Reg_M)
      M2R_ALU: w_result = ALUout_M;
      M2R_MEM: w_result = w_load;
      M2R_PC8: w_result = w_pc8;
      default: w_result = 32'h0;
    endcase
  end

  // Pipeline register bank: reset, then flush bubble, then stall hold, else capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_mem2reg  <= 2'b00;
      r_wregadd  <= 5'd0;
      r_instr    <= 32'h0;
      r_result   <= 32'h0;
      r_pc       <= RESET_PC;
      r_pc8      <= RESET_PC + 32'd8;
    end else if (flush_W) begin
      // Bubble keeps the PC so the WB stage still shows where it came from
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_mem2reg  <= 2'b00;
      r_wregadd  <= 5'd0;
      r_instr    <= 32'h0;
      r_result   <= 32'h0;
      r_pc       <= PC_M;
      r_pc8      <= w_pc8;
    end else if (!stall_W) begin
      r_valid    <= valid_M;
      r_regwrite <= w_regwrite;
      r_mem2reg  <= Mem2Reg_M;
      r_wregadd  <= WRegAdd_M;
      r_instr    <= instr_M;
      r_result   <= w_result;
      r_pc       <= PC_M;
      r_pc8      <= w_pc8;
    end
  end

  // Retired-instruction counter: counts valid instructions actually entering WB
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_retire_cnt <= '0;
    end else if (!flush_W && !stall_W && valid_M) begin
      r_retire_cnt <= r_retire_cnt + CNT_W'(1);
    end
  end

  assign valid_W    = r_valid;
  assign RegWrite_W = r_regwrite;
  assign Mem2Reg_W  = r_mem2reg;
  assign WRegAdd_W  = r_wregadd;
  assign instr_W    = r_instr;
  assign result_W   = r_result;
  assign PC_W       = r_pc;
  assign PC8_W      = r_pc8;
  assign retire_cnt = r_retire_cnt;

endmodule

// File: tb/tb_mem_wb_reg.sv
// Scoreboard bench for mem_wb_reg: directed vectors push expected WB state,
// a monitor pops and compares one entry after each rising edge.
// Counter width is reduced to 4 bits so the wrap is reachable quickly.
module tb_mem_wb_reg;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          stall_W, flush_W, valid_M, RegWrite_M;
  logic [1:0]    Mem2Reg_M;
  logic [4:0]    WRegAdd_M;
  logic [31:0]   instr_M, ALUout_M, DMout_M, PC_M;
  logic          valid_W, RegWrite_W;
  logic [1:0]    Mem2Reg_W;
  logic [4:0]    WRegAdd_W;
  logic [31:0]   instr_W, result_W, PC_W, PC8_W;
  logic [CW-1:0] retire_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic          v;
    logic          rw;
    logic [1:0]    m2r;
    logic [4:0]    wr;
    logic [31:0]   ins;
    logic [31:0]   res;
    logic [31:0]   pc;
    logic [31:0]   pc8;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t m;
  exp_t q[$];

  mem_wb_reg #(.RESET_PC(32'h0000_3000), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .stall_W(stall_W), .flush_W(flush_W),
    .valid_M(valid_M), .RegWrite_M(RegWrite_M), .Mem2Reg_M(Mem2Reg_M),
    .WRegAdd_M(WRegAdd_M), .instr_M(instr_M), .ALUout_M(ALUout_M),
    .DMout_M(DMout_M), .PC_M(PC_M), .valid_W(valid_W),
    .RegWrite_W(RegWrite_W), .Mem2Reg_W(Mem2Reg_W), .WRegAdd_W(WRegAdd_W),
    .instr_W(instr_W), .result_W(result_W), .PC_W(PC_W), .PC8_W(PC8_W),
    .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_reset_model();
    m = '0;
    m.pc  = 32'h0000_3000;
    m.pc8 = 32'h0000_3008;
  endtask

  task automatic check_reset(input string tag);
    cmp({tag, ".valid"},  {31'h0, valid_W},    32'h0);
    cmp({tag, ".rw"},     {31'h0, RegWrite_W}, 32'h0);
    cmp({tag, ".m2r"},    {30'h0, Mem2Reg_W},  32'h0);
    cmp({tag, ".wreg"},   {27'h0, WRegAdd_W},  32'h0);
    cmp({tag, ".instr"},  instr_W,             32'h0);
    cmp({tag, ".result"}, result_W,            32'h0);
    cmp({tag, ".pc"},     PC_W,                32'h0000_3000);
    cmp({tag, ".pc8"},    PC8_W,               32'h0000_3008);
    cmp({tag, ".cnt"},    32'(retire_cnt),     32'h0);
  endtask

  // One stimulus cycle: drive at the falling edge and queue the expected post-edge state
  task automatic step(input logic v, input logic rw, input logic [1:0] m2r,
                      input logic [4:0] wr, input logic [31:0] ins,
                      input logic [31:0] alu, input logic [31:0] dm,
                      input logic [31:0] pc, input logic st, input logic fl,
                      input logic [31:0] exp_res);
    @(negedge clk);
    valid_M = v; RegWrite_M = rw; Mem2Reg_M = m2r; WRegAdd_M = wr;
    instr_M = ins; ALUout_M = alu; DMout_M = dm; PC_M = pc;
    stall_W = st; flush_W = fl;
    if (fl) begin
      m.v = 1'b0; m.rw = 1'b0; m.m2r = 2'b00; m.wr = 5'd0;
      m.ins = 32'h0; m.res = 32'h0; m.pc = pc; m.pc8 = pc + 32'd8;
    end else if (!st) begin
      m.v = v; m.rw = rw & v & (wr != 5'd0); m.m2r = m2r; m.wr = wr;
      m.ins = ins; m.res = exp_res; m.pc = pc; m.pc8 = pc + 32'd8;
      if (v) m.cnt = m.cnt + 1'b1;
    end
    q.push_back(m);
  endtask

  // Monitor: one expected entry per edge following a queued stimulus
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        cmp("valid_W",    {31'h0, valid_W},    {31'h0, e.v});
        cmp("RegWrite_W", {31'h0, RegWrite_W}, {31'h0, e.rw});
        cmp("Mem2Reg_W",  {30'h0, Mem2Reg_W},  {30'h0, e.m2r});
        cmp("WRegAdd_W",  {27'h0, WRegAdd_W},  {27'h0, e.wr});
        cmp("instr_W",    instr_W,             e.ins);
        cmp("result_W",   result_W,            e.res);
        cmp("PC_W",       PC_W,                e.pc);
        cmp("PC8_W",      PC8_W,               e.pc8);
        cmp("retire_cnt", 32'(retire_cnt),     32'(e.cnt));
        if (!valid_W) cmp("bubble_rw", {31'h0, RegWrite_W}, 32'h0);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin : stim
    reset = 1'b1; stall_W = 1'b1; flush_W = 1'b0; valid_M = 1'b0;
    RegWrite_M = 1'b0; Mem2Reg_M = 2'b00; WRegAdd_M = 5'd0; instr_M = 32'h0;
    ALUout_M = 32'h0; DMout_M = 32'h0; PC_M = 32'h0;
    #2;
    check_reset("rst_init");
    set_reset_model();
    @(negedge clk);
    reset = 1'b0;

    // Loads: lb/lbu/lh/lhu/lw and lane-0 cases
    step(1, 1, 2'b01, 5'd3, 32'h8000_0001, 32'h0000_1001, 32'h1280_FF7F, 32'h0000_3000, 0, 0, 32'hFFFF_FFFF);
    step(1, 1, 2'b01, 5'd4, 32'h9000_0002, 32'h0000_1002, 32'h1280_FF7F, 32'h0000_3004, 0, 0, 32'h0000_0080);
    step(1, 1, 2'b01, 5'd5, 32'h8400_0003, 32'h0000_2002, 32'h8001_1234, 32'h0000_3008, 0, 0, 32'hFFFF_8001);
    step(1, 1, 2'b01, 5'd6, 32'h9400_0004, 32'h0000_2003, 32'h8001_1234, 32'h0000_300C, 0, 0, 32'h0000_8001);
    step(1, 1, 2'b01, 5'd7, 32'h8C00_0005, 32'h0000_2001, 32'hDEAD_BEEF, 32'h0000_3010, 0, 0, 32'hDEAD_BEEF);
    step(1, 1, 2'b01, 5'd8, 32'h8000_0006, 32'h0000_1000, 32'h1280_FF7F, 32'h0000_3014, 0, 0, 32'h0000_007F);
    step(1, 1, 2'b01, 5'd9, 32'h8400_0007, 32'h0000_1000, 32'h8001_1234, 32'h0000_3018, 0, 0, 32'h0000_1234);
    // jal link to $31, then to $0 (write suppressed)
    step(1, 1, 2'b10, 5'd31, 32'h0C00_0010, 32'h0000_0055, 32'h0, 32'h0000_3010, 0, 0, 32'h0000_3018);
    step(1, 1, 2'b10, 5'd0,  32'h0C00_0010, 32'h0000_0055, 32'h0, 32'h0000_3010, 0, 0, 32'h0000_3018);
    // ALU, reserved select, PC+8 wrap
    step(1, 1, 2'b00, 5'd10, 32'h0022_1820, 32'h1234_5678, 32'hFFFF_FFFF, 32'h0000_3020, 0, 0, 32'h1234_5678);
    step(1, 1, 2'b11, 5'd11, 32'h0022_1821, 32'h1234_5678, 32'hFFFF_FFFF, 32'h0000_3024, 0, 0, 32'h0000_0000);
    step(1, 1, 2'b10, 5'd12, 32'h0C00_0020, 32'h0000_0000, 32'h0,         32'hFFFF_FFFC, 0, 0, 32'h0000_0004);
    // Invalid slot: captured but not retired and no write
    step(0, 1, 2'b00, 5'd5, 32'h0000_0077, 32'h0000_0077, 32'h0, 32'h0000_3030, 0, 0, 32'h0000_0077);
    // Re-load a real instruction, then stall three cycles with changing inputs
    step(1, 1, 2'b00, 5'd13, 32'h0000_1111, 32'hCAFE_0001, 32'h0, 32'h0000_3034, 0, 0, 32'hCAFE_0001);
    for (int i = 0; i < 3; i++)
      step(1, 1, 2'b01, 5'(20 + i), 32'hAAAA_0000 + 32'(i), 32'h0000_0100 + 32'(i),
           32'h5555_0000 + 32'(i), 32'h0000_4000 + 32'(4 * i), 1, 0, 32'h0);
    // Flush together with stall: bubble wins
    step(1, 1, 2'b00, 5'd14, 32'hBBBB_0000, 32'h0000_0999, 32'h0, 32'h0000_3040, 1, 1, 32'h0);

    // Asynchronous reset between edges, overriding stall and flush
    @(posedge clk);
    #2;
    stall_W = 1'b1; flush_W = 1'b1; reset = 1'b1;
    #1;
    check_reset("rst_mid");
    set_reset_model();
    @(negedge clk);
    reset = 1'b0; flush_W = 1'b0;

    // Five valid instructions, the middle one flushed -> four retired
    for (int i = 0; i < 5; i++)
      step(1, 1, 2'b00, 5'd1, 32'h0000_0100 + 32'(i), 32'h0000_0010 + 32'(i), 32'h0,
           32'h0000_3000 + 32'(4 * i), 0, (i == 2), 32'h0000_0010 + 32'(i));
    // Run the 4-bit counter up to all-ones, then one more wraps to zero
    for (int i = 0; i < 12; i++)
      step(1, 1, 2'b00, 5'd2, 32'h0000_0200 + 32'(i), 32'h0000_0020 + 32'(i), 32'h0,
           32'h0000_3100 + 32'(4 * i), 0, 0, 32'h0000_0020 + 32'(i));

    @(posedge clk);
    #2;
    cmp("queue_drained", 32'(q.size()), 32'h0);
    cmp("final_cnt", 32'(retire_cnt), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
